// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath (feeder, inverter, deserialiser).
// Holds the default word width and the feeder FSM state encoding.
// No logic lives here.
package serial_pkg;

  // Default word width shared by every stage of the serial chain
  localparam int SER_WIDTH = 8;

  // Feeder frame states: waiting, one-cycle frame clear, bit shifting
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } ser_state_e;

endpackage

// File: rtl/serial_word_feeder.sv
// Serialises parallel words LSB-first, preceded by a one-cycle frame clear.
// Latency: transfer at edge k -> ser_clr in cycle k+1, bit 0 in k+2, MSB in k+WIDTH+1.
// Backpressure: in_ready only in IDLE or on the last SHIFT cycle; one word per WIDTH+1 cycles.
module serial_word_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_clr,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;

  // The final SHIFT cycle is where a frame may hand over to the next word
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // State, shift register and bit counter; reset abandons any frame in flight
  always_ff @(posedge t_clk) begin
    if (!r_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: capture on transfer, clear for one cycle, then shift WIDTH bits
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CLR;
          shreg_d = in_data;
        end
      end
      CLR: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_q == LAST_CNT) begin
          // Counter is reset on exit so it never wraps on its own
          cnt_d = '0;
          if (in_valid) begin
            state_d = CLR;
            shreg_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state only; in_valid never reaches these
  always_comb begin
    in_ready  = (state_q == IDLE) || last_bit;
    ser_clr   = (state_q == CLR);
    ser_valid = (state_q == SHIFT);
    ser_bit   = (state_q == SHIFT) && shreg_q[0];
    ser_last  = last_bit;
    busy      = (state_q != IDLE);
  end

endmodule
